// File: rtl/seq_detect_ctrl.sv
// Run controller for serial pattern detection: programmable pattern, overlapping or
// non-overlapping hit counting, run ends on a bit window or hit target. Optional irq via SEQ_DET_IRQ_EN.
module seq_detect_ctrl #(
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_load,
  input  logic [PAT_MAX-1:0]        cfg_pattern,
  input  logic [$clog2(PAT_MAX):0]  cfg_len,
  input  logic                      cfg_overlap,
  input  logic [WIN_W-1:0]          cfg_win_len,
  input  logic [CNT_W-1:0]          cfg_target,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      in_valid,
  input  logic                      in,
  output logic                      in_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      det_pulse,
  output logic [CNT_W-1:0]          det_count
`ifdef SEQ_DET_IRQ_EN
  ,
  output logic                      irq,
  input  logic                      irq_clr
`endif
);

  localparam int LEN_W = $clog2(PAT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic               run_q;
  logic               done_q;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [WIN_W-1:0]   win_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [PAT_MAX-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [WIN_W-1:0]   bit_cnt;

  logic               accept;
  logic               launch;
  logic               hit;
  logic               end_run;
  logic [LEN_W-1:0]   len_eff;
  logic [PAT_MAX-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [WIN_W-1:0]   bit_cnt_next;
  logic [CNT_W-1:0]   cnt_next;

  // Length 0 means 1; anything longer than the history register is clamped.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)
      return LEN_W'(1);
    else if (l > LEN_W'(PAT_MAX))
      return LEN_W'(PAT_MAX);
    else
      return l;
  endfunction

  function automatic logic [PAT_MAX-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [PAT_MAX-1:0] m;
    for (int i = 0; i < PAT_MAX; i++)
      m[i] = (i < int'(l));
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == '1)
      return c;
    else
      return c + CNT_W'(1);
  endfunction

  assign in_ready = run_q;
  assign busy     = run_q;
  assign done     = done_q;

  assign accept       = in_valid & run_q;
  assign launch       = start & ((state == IDLE) | (state == DONE));
  assign len_eff      = clamp_len(len_q);
  assign hist_next    = {hist[PAT_MAX-2:0], in};
  assign fill_next    = (fill >= LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : fill + LEN_W'(1);
  assign bit_cnt_next = bit_cnt + WIN_W'(1);
  assign hit          = accept && (fill_next >= len_eff) &&
                        (((hist_next ^ pat_q) & len_mask(len_eff)) == '0);
  assign cnt_next     = hit ? sat_inc(det_count) : det_count;
  assign end_run      = accept && (((win_q != '0) && (bit_cnt_next == win_q)) ||
                                   ((tgt_q != '0) && (cnt_next == tgt_q)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      det_pulse <= 1'b0;
      det_count <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      win_q     <= '0;
      tgt_q     <= '0;
      hist      <= '0;
      fill      <= '0;
      bit_cnt   <= '0;
    end else begin
      det_pulse <= 1'b0;
      if (cfg_load && (state == IDLE)) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        win_q <= cfg_win_len;
        tgt_q <= cfg_target;
      end
      // stop has priority over start and over any bit accepted in the same cycle
      if (stop) begin
        state  <= IDLE;
        run_q  <= 1'b0;
        done_q <= 1'b0;
      end else if (launch) begin
        state     <= RUN;
        run_q     <= 1'b1;
        done_q    <= 1'b0;
        hist      <= '0;
        fill      <= '0;
        bit_cnt   <= '0;
        det_count <= '0;
      end else if ((state == RUN) && accept) begin
        hist      <= hist_next;
        fill      <= (hit && !ovl_q) ? '0 : fill_next;
        bit_cnt   <= bit_cnt_next;
        det_count <= cnt_next;
        det_pulse <= hit;
        if (end_run) begin
          state  <= DONE;
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

`ifdef SEQ_DET_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset)
      irq <= 1'b0;
    else if (!stop && (state == RUN) && end_run)
      irq <= 1'b1;
    else if (irq_clr)
      irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a behavioural model pushes expected results per driven bit,
// popped and compared one cycle later. A second instance with CNT_W=2 covers saturation.
module tb_seq_detect_ctrl;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 8;
  localparam int WIN_W   = 16;
  localparam int LEN_W   = $clog2(PAT_MAX) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1, cfg_load = 1'b0, start = 1'b0, stop = 1'b0;
  logic in_valid = 1'b0, in = 1'b0, cfg_overlap = 1'b0;
  logic [PAT_MAX-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic [WIN_W-1:0]   cfg_win_len = '0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic in_ready, busy, done, det_pulse;
  logic [CNT_W-1:0] det_count;
  logic in_ready_s, busy_s, done_s, det_pulse_s;
  logic [1:0] det_count_s;
`ifdef SEQ_DET_IRQ_EN
  logic irq, irq_s;
  logic irq_clr = 1'b0;
`endif

  seq_detect_ctrl #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_win_len(cfg_win_len),
    .cfg_target(cfg_target), .start(start), .stop(stop), .in_valid(in_valid), .in(in),
    .in_ready(in_ready), .busy(busy), .done(done), .det_pulse(det_pulse), .det_count(det_count)
`ifdef SEQ_DET_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  seq_detect_ctrl #(.PAT_MAX(PAT_MAX), .CNT_W(2), .WIN_W(WIN_W)) dut_s (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_win_len(cfg_win_len),
    .cfg_target(cfg_target[1:0]), .start(start), .stop(stop), .in_valid(in_valid), .in(in),
    .in_ready(in_ready_s), .busy(busy_s), .done(done_s), .det_pulse(det_pulse_s),
    .det_count(det_count_s)
`ifdef SEQ_DET_IRQ_EN
    , .irq(irq_s), .irq_clr(irq_clr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pulse;
    logic [7:0] cnt;
    logic       dn;
    logic [1:0] cnt_s;
  } exp_t;
  exp_t sb[$];

  // Model state: 0 = idle, 1 = run, 2 = done
  int         m_state = 0;
  logic [7:0] m_pat = '0;
  int         m_len = 1, m_win = 0, m_tgt = 0, m_cnt = 0, m_cnt_s = 0, m_bitcnt = 0;
  bit         m_ovl = 0;
  bit         m_bits[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_pat = '0; m_len = 1; m_win = 0; m_tgt = 0;
    m_ovl = 0; m_cnt = 0; m_cnt_s = 0; m_bitcnt = 0;
    m_bits.delete();
  endtask

  task automatic model_bit(input bit b, output exp_t e);
    bit hit;
    hit = 0;
    if (m_state == 1) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_MAX) void'(m_bits.pop_front());
      m_bitcnt++;
      if (m_bits.size() >= m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++)
          if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
      end
      if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
        if (!m_ovl) m_bits.delete();
      end
      if ((m_win != 0 && m_bitcnt == m_win) || (m_tgt != 0 && m_cnt == m_tgt))
        m_state = 2;
    end
    e.pulse = hit;
    e.cnt   = 8'(m_cnt);
    e.dn    = (m_state == 2);
    e.cnt_s = 2'(m_cnt_s);
  endtask

  task automatic send_bit(input bit b, input bit chk_s);
    exp_t e;
    in_valid = 1'b1;
    in = b;
    model_bit(b, e);
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    e = sb.pop_front();
    check("det_pulse", det_pulse, e.pulse);
    check("det_count", det_count, e.cnt);
    check("done", done, e.dn);
    if (chk_s) check("det_count_sat", det_count_s, e.cnt_s);
  endtask

  task automatic gap();
    step();
    check("gap_det_pulse", det_pulse, 0);
    check("gap_busy", busy, m_state == 1);
  endtask

  task automatic do_cfg(input logic [7:0] pat, input int len, input bit ovl,
                        input int win, input int tgt, input bit with_start);
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    cfg_win_len = WIN_W'(win);
    cfg_target  = CNT_W'(tgt);
    cfg_load    = 1'b1;
    start       = with_start;
    if (m_state == 0) begin
      m_pat = pat;
      m_len = (len == 0) ? 1 : (len > PAT_MAX) ? PAT_MAX : len;
      m_ovl = ovl; m_win = win; m_tgt = tgt;
    end
    if (with_start && m_state != 1) begin
      m_state = 1; m_cnt = 0; m_cnt_s = 0; m_bitcnt = 0; m_bits.delete();
    end
    step();
    cfg_load = 1'b0;
    start    = 1'b0;
    if (with_start) check("start_busy", busy, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    if (m_state != 1) begin
      m_state = 1; m_cnt = 0; m_cnt_s = 0; m_bitcnt = 0; m_bits.delete();
    end
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 1);
    check("start_done", done, 0);
    check("start_det_count", det_count, m_cnt);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    m_state = 0;
    step();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
  endtask

  task automatic send_stream(input logic [6:0] bits);
    for (int i = 6; i >= 0; i--) send_bit(bits[i], 0);
  endtask

  initial begin
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_det_pulse", det_pulse, 0);
    check("rst_det_count", det_count, 0);
    reset = 1'b0;
    model_reset();

    // Overlapping 1101 over 1101101: hits after bits 4 and 7
    do_cfg(8'b1101, 4, 1, 0, 0, 0);
    do_start();
    send_stream(7'b1101101);
    check("ovl_count", det_count, 2);
    do_stop();

    // Non-overlapping, config latched in the same cycle as start
    do_cfg(8'b1101, 4, 0, 0, 0, 1);
    send_stream(7'b1101101);
    check("novl_count", det_count, 1);
    do_stop();

    // Window of 5 bits with valid gaps; later bits ignored in DONE
    do_cfg(8'b1101, 4, 1, 5, 0, 0);
    do_start();
    send_bit(1, 0); gap();
    send_bit(1, 0); gap(); gap();
    send_bit(0, 0); gap();
    send_bit(1, 0); gap();
    send_bit(1, 0);
    check("win_done", done, 1);
    check("win_in_ready", in_ready, 0);
    send_bit(1, 0);
    send_bit(1, 0);
    check("win_count_hold", det_count, 1);
    do_stop();

    // Hit target of 2 ends the run; restart from DONE clears the count
    do_cfg(8'b1101, 4, 1, 0, 2, 0);
    do_start();
    send_stream(7'b1101101);
    check("tgt_done", done, 1);
    check("tgt_count", det_count, 2);
    do_start();
    check("restart_count", det_count, 0);
    do_stop();

    // cfg_load during RUN is ignored: 101 must not hit on 1,0,1,...
    do_cfg(8'b1101, 4, 1, 0, 0, 0);
    do_start();
    do_cfg(8'b101, 3, 0, 0, 0, 0);
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    check("cfg_run_count", det_count, 1);
    send_bit(1, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_det_pulse", det_pulse, 0);
    check("mid_rst_det_count", det_count, 0);

    // start and stop together: stop wins
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", busy, 0);

    // len 0 treated as 1, pattern "1"; CNT_W=2 instance saturates at 3
    do_cfg(8'b1, 0, 1, 0, 0, 0);
    do_start();
    for (int i = 0; i < 5; i++) send_bit(1, 1);
    check("sat_count", det_count_s, 3);
    check("nosat_count", det_count, 5);
    do_stop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
